// File: rtl/param_echo_tx.sv
// UART readback of the pulse-parameter set as a fixed 8N1 byte frame.
// Define PARAM_ECHO_CHECKSUM_EN to append a mod-256 checksum byte (13-byte frame).
//
// state    | meaning
// ST_IDLE  | line idle high, waiting for start
// ST_START | start bit (low) of the current byte
// ST_DATA  | data bits, LSB first
// ST_STOP  | stop bit (high); last byte goes to ST_DONE
// ST_DONE  | one-cycle done pulse; start is accepted here too
module param_echo_tx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic        cp,
    input  logic        bl,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);
`ifdef PARAM_ECHO_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd12;
`else
    localparam logic [3:0] LAST_BYTE = 4'd11;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [15:0] clk_cnt;
    logic        bit_tick;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [7:0]  tx_byte;

    logic [31:0] per_q;
    logic [15:0] p1wid_q;
    logic [15:0] del_q;
    logic [15:0] p2wid_q;
    logic        cp_q;
    logic        bl_q;

    assign bit_tick = (clk_cnt == 16'd0);

`ifdef PARAM_ECHO_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = per_q[31:24] + per_q[23:16] + per_q[15:8] + per_q[7:0]
                + p1wid_q[15:8] + p1wid_q[7:0] + del_q[15:8] + del_q[7:0]
                + p2wid_q[15:8] + p2wid_q[7:0] + {6'b0, bl_q, cp_q};
`endif

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            4'd0:  tx_byte = 8'hA5;
            4'd1:  tx_byte = per_q[31:24];
            4'd2:  tx_byte = per_q[23:16];
            4'd3:  tx_byte = per_q[15:8];
            4'd4:  tx_byte = per_q[7:0];
            4'd5:  tx_byte = p1wid_q[15:8];
            4'd6:  tx_byte = p1wid_q[7:0];
            4'd7:  tx_byte = del_q[15:8];
            4'd8:  tx_byte = del_q[7:0];
            4'd9:  tx_byte = p2wid_q[15:8];
            4'd10: tx_byte = p2wid_q[7:0];
            4'd11: tx_byte = {6'b0, bl_q, cp_q};
`ifdef PARAM_ECHO_CHECKSUM_EN
            4'd12: tx_byte = csum;
`endif
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        RS232_Tx  = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_START;
                    accept    = 1'b1;
                end
            end
            ST_START: begin
                RS232_Tx = 1'b0;
                busy     = 1'b1;
                if (bit_tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                RS232_Tx = tx_byte[bit_idx];
                busy     = 1'b1;
                if (bit_tick && bit_idx == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                busy = 1'b1;
                if (bit_tick) state_nxt = (byte_idx == LAST_BYTE) ? ST_DONE : ST_START;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = ST_START;
                    accept    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset wins over accept, so start is ignored while resetn is low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            per_q    <= '0;
            p1wid_q  <= '0;
            del_q    <= '0;
            p2wid_q  <= '0;
            cp_q     <= 1'b0;
            bl_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                clk_cnt  <= BIT_LOAD;
                bit_idx  <= '0;
                byte_idx <= '0;
                per_q    <= per;
                p1wid_q  <= p1wid;
                del_q    <= del;
                p2wid_q  <= p2wid;
                cp_q     <= cp;
                bl_q     <= bl;
            end else if (busy) begin
                if (bit_tick) begin
                    clk_cnt <= BIT_LOAD;
                    if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
                    if (state == ST_STOP) byte_idx <= byte_idx + 4'd1;
                end else begin
                    clk_cnt <= clk_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_echo_tx.sv
// Bench for param_echo_tx: two instances (4 and 7 clocks per bit) against a
// bit-string frame model, plus directed frames with literal byte/timing expectations.
module tb_param_echo_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 7;
`ifdef PARAM_ECHO_CHECKSUM_EN
    localparam int NB      = 13;
    localparam int END_LIT = 520;
`else
    localparam int NB      = 12;
    localparam int END_LIT = 480;
`endif

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] per    = '0;
    logic [15:0] p1wid  = '0;
    logic [15:0] del    = '0;
    logic [15:0] p2wid  = '0;
    logic        cp     = 1'b0;
    logic        bl     = 1'b0;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;
    logic [1:0]  tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

    logic [7:0] lit [0:12] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h00, 8'h10,
                               8'h00, 8'h20, 8'h00, 8'h30, 8'h03, 8'hCC};

    always #5 clk = ~clk;

    param_echo_tx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
        .clk(clk), .resetn(resetn), .start(start), .per(per), .p1wid(p1wid),
        .del(del), .p2wid(p2wid), .cp(cp), .bl(bl),
        .RS232_Tx(tx_a), .busy(busy_a), .done(done_a));

    param_echo_tx #(.CLKS_PER_BIT(CPB_B)) u_dut_b (
        .clk(clk), .resetn(resetn), .start(start), .per(per), .p1wid(p1wid),
        .del(del), .p2wid(p2wid), .cp(cp), .bl(bl),
        .RS232_Tx(tx_b), .busy(busy_b), .done(done_b));

    assign tx_v   = {tx_b, tx_a};
    assign busy_v = {busy_b, busy_a};
    assign done_v = {done_b, done_a};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cpb_of(input int k);
        return (k == 0) ? CPB_A : CPB_B;
    endfunction

    // Model: a frame is a string of NB*10 line levels, each lasting cpb cycles.
    bit mbits [0:1][0:129];
    int mt    [0:1];
    bit mact  [0:1];
    bit mdn   [0:1];

    task automatic load_frame(input int k);
        logic [7:0] fb [0:12];
        fb[0]  = 8'hA5;
        fb[1]  = per[31:24];  fb[2]  = per[23:16];
        fb[3]  = per[15:8];   fb[4]  = per[7:0];
        fb[5]  = p1wid[15:8]; fb[6]  = p1wid[7:0];
        fb[7]  = del[15:8];   fb[8]  = del[7:0];
        fb[9]  = p2wid[15:8]; fb[10] = p2wid[7:0];
        fb[11] = {6'b0, bl, cp};
        fb[12] = 8'h00;
        for (int i = 1; i <= 11; i++) fb[12] = fb[12] + fb[i];
        for (int i = 0; i < NB; i++) begin
            mbits[k][10*i] = 1'b0;
            for (int j = 0; j < 8; j++) mbits[k][10*i+1+j] = fb[i][j];
            mbits[k][10*i+9] = 1'b1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mact[k] = 1'b0; mdn[k] = 1'b0; mt[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                mact[k] = 1'b0;
                mdn[k]  = 1'b0;
            end else if (mact[k]) begin
                mt[k]++;
                if (mt[k] == NB*10*cpb_of(k)) begin
                    mact[k] = 1'b0;
                    mdn[k]  = 1'b1;
                end
            end else if (start) begin
                load_frame(k);
                mact[k] = 1'b1;
                mt[k]   = 0;
                mdn[k]  = 1'b0;
            end else begin
                mdn[k] = 1'b0;
            end
        end
    end

    // Per-cycle compare, plus run lengths of each line level within a frame.
    bit ptx [0:1], pbusy [0:1], trk [0:1];
    int run [0:1];
    initial for (int k = 0; k < 2; k++) begin ptx[k] = 1'b1; pbusy[k] = 1'b0; trk[k] = 1'b0; run[k] = 0; end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            logic exp_tx;
            exp_tx = mact[k] ? mbits[k][mt[k] / cpb_of(k)] : 1'b1;
            chk(k == 0 ? "tx_cpb4" : "tx_cpb7", 32'(tx_v[k]), 32'(exp_tx));
            chk(k == 0 ? "busy_cpb4" : "busy_cpb7", 32'(busy_v[k]), 32'(mact[k]));
            chk(k == 0 ? "done_cpb4" : "done_cpb7", 32'(done_v[k]), 32'(mdn[k]));
            if (!resetn) begin
                trk[k] = 1'b0;
            end else if (busy_v[k] && (!pbusy[k] || tx_v[k] != ptx[k])) begin
                if (trk[k]) chk(k == 0 ? "runlen_cpb4" : "runlen_cpb7", 32'(run[k] % cpb_of(k)), 0);
                trk[k] = 1'b1;
                run[k] = 1;
            end else if (trk[k] && busy_v[k]) begin
                run[k]++;
            end else if (trk[k]) begin
                chk(k == 0 ? "runlen_cpb4" : "runlen_cpb7", 32'(run[k] % cpb_of(k)), 0);
                trk[k] = 1'b0;
            end
            ptx[k]   = tx_v[k];
            pbusy[k] = busy_v[k];
        end
    end

    task automatic set_ref_inputs();
        per = 32'h0001_2345; p1wid = 16'h0010; del = 16'h0020; p2wid = 16'h0030;
        cp = 1'b1; bl = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, want idle", n);
        end
    endtask

    // Decode the 4-cycle instance at mid-bit against the literal frame.
    task automatic run_frame(input bit change_per);
        int m;
        logic [7:0] got;
        set_ref_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 0;
        chk("first_start_bit", 32'(tx_a), 0);
        chk("busy_at_start", 32'(busy_a), 1);
        for (int i = 0; i < NB; i++) begin
            got = 8'h00;
            for (int j = 0; j < 8; j++) begin
                while (m < (10*i + 1 + j)*CPB_A + 2) begin
                    @(negedge clk);
                    m++;
                    if (change_per && m == 10) per = 32'hFFFF_FFFF;
                end
                got[j] = tx_a;
            end
            chk($sformatf("byte%0d", i), 32'(got), 32'(lit[i]));
        end
        while (m < END_LIT - 1) begin @(negedge clk); m++; end
        chk("done_not_early", 32'(done_a), 0);
        @(negedge clk);
        chk("done_at_frame_end", 32'(done_a), 1);
        chk("busy_low_in_done", 32'(busy_a), 0);
    endtask

    initial begin
        int n;
        int dn;
        repeat (3) @(negedge clk);
        chk("reset_tx_a", 32'(tx_a), 1);
        chk("reset_busy_a", 32'(busy_a), 0);
        chk("reset_done_a", 32'(done_a), 0);
        chk("reset_tx_b", 32'(tx_b), 1);
        chk("reset_busy_b", 32'(busy_b), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        wait_idle();
        run_frame(1'b0);
        wait_idle();
        run_frame(1'b1);

        // start held high: next frame begins on the edge after done
        wait_idle();
        set_ref_inputs();
        start = 1'b1;
        n = 0;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        chk("b2b_done_cycle", 32'(n), 32'(END_LIT + 1));
        @(negedge clk);
        chk("b2b_restart_tx", 32'(tx_a), 0);
        chk("b2b_restart_busy", 32'(busy_a), 1);
        start = 1'b0;
        wait_idle();

        // reset during byte 5 aborts without done; start ignored under reset
        set_ref_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (215) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_tx_a", 32'(tx_a), 1);
        chk("abort_busy_a", 32'(busy_a), 0);
        chk("abort_done_a", 32'(done_a), 0);
        chk("abort_tx_b", 32'(tx_b), 1);
        chk("abort_busy_b", 32'(busy_b), 0);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_reset_ignored", 32'(busy_a), 0);
        start = 1'b0;
        resetn = 1'b1;
        dn = 0;
        repeat (1000) begin @(negedge clk); if (done_a || done_b) dn++; end
        chk("no_done_after_abort", 32'(dn), 0);
        run_frame(1'b0);
        wait_idle();

        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 2999) != 0);
            start  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) per   = $urandom;
            if ($urandom_range(0, 3) == 0) p1wid = 16'($urandom);
            if ($urandom_range(0, 3) == 0) del   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) p2wid = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cp    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bl    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        resetn = 1'b1;
        start  = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/param_echo_tx.md
PARAM_ECHO_TX -- requirements
Module: param_echo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104; clock cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  readback request; level sampled each cycle.
REQ-005 SHALL have port per  input  32  pulse period setting.
REQ-006 SHALL have port p1wid  input  16  pulse-1 width setting.
REQ-007 SHALL have port del  input  16  pulse delay setting.
REQ-008 SHALL have port p2wid  input  16  pulse-2 width setting.
REQ-009 SHALL have port cp  input  1  CPMG mode flag.
REQ-010 SHALL have port bl  input  1  blanking flag.
REQ-011 SHALL have port RS232_Tx  output  1  UART serial line to the FTDI chip; idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL accept start only in IDLE; start while busy is ignored and not queued.
REQ-015 SHALL, on accept, snapshot per, p1wid, del, p2wid, cp, bl into internal registers; later input changes SHALL NOT affect the frame in progress.
REQ-016 SHALL drive RS232_Tx low (start bit of byte 0) and busy high on the clock edge after the edge where start is sampled.
REQ-017 SHALL send frame bytes in order: 0xA5; per[31:24], per[23:16], per[15:8], per[7:0]; p1wid MSB then LSB; del MSB then LSB; p2wid MSB then LSB; flags byte {6'b0, bl, cp}.
REQ-018 SHALL send each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-019 SHALL send bytes back-to-back; the next start bit immediately follows the previous stop bit, with no idle gap.
REQ-020 SHALL use states IDLE -> START -> DATA (8 bits) -> STOP -> (START for the next byte | DONE), and DONE -> IDLE after one cycle.
REQ-021 SHALL assert done for exactly one cycle, in the cycle after the final stop bit ends; busy SHALL be low in that cycle.
REQ-022 SHALL accept a start that is high during the done cycle; RS232_Tx goes low on the following edge.
REQ-023 SHALL make total frame duration N*10*CLKS_PER_BIT cycles, where N is the byte count.
REQ-024 SHALL hold RS232_Tx high whenever not transmitting.

Reset
REQ-025 SHALL, with resetn low at a clock edge, set RS232_Tx=1, busy=0, done=0, state IDLE, and bit/byte counters 0.
REQ-026 SHALL abort any frame in progress on reset without a done pulse; RS232_Tx goes high on that edge.
REQ-027 SHALL ignore start in any cycle where resetn is low.

Configuration
REQ-028 SHALL, with macro PARAM_ECHO_CHECKSUM_EN defined, append a 13th byte equal to the mod-256 sum of bytes 1..11 (0xA5 header excluded); N=13.
REQ-029 SHALL, without PARAM_ECHO_CHECKSUM_EN, end the frame after the flags byte; N=12, and no checksum logic is present.

Verification
REQ-030 SHALL cover this scenario: CLKS_PER_BIT=4, macro defined, per=0x00012345, p1wid=0x0010, del=0x0020, p2wid=0x0030, cp=1, bl=1, start pulse -> decoded bytes A5 00 01 23 45 00 10 00 20 00 30 03 CC; done exactly 520 cycles after the first start bit.
REQ-031 SHALL cover this scenario: same stimulus with the macro undefined -> 12 bytes ending 03; done after 480 cycles.
REQ-032 SHALL cover this scenario: change per to 0xFFFFFFFF at cycle 10 of the frame -> transmitted per bytes remain 00 01 23 45.
REQ-033 SHALL cover this scenario: start held high through the entire frame -> a second frame starts on the edge after done, with no idle bit between frames.
REQ-034 SHALL cover this scenario: resetn low during byte 5 -> RS232_Tx=1, busy=0 on the next edge; no done pulse; a fresh start afterwards sends a full, correct frame.
REQ-035 SHALL cover this scenario: bit-timing check, CLKS_PER_BIT=7 -> every RS232_Tx level is held exactly 7 cycles per bit, or a multiple of 7 for repeated bit values.
